// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
//
// Owns the architectural fetch PC and keeps at most one word request
// outstanding to the instruction cache. Returned words are buffered in a
// QDEPTH-entry FIFO together with their PC and presented to decode under a
// valid/stall handshake. A redirect flushes the FIFO, discards any
// in-flight response and restarts fetch at the new PC.
//
// Optional feature macro: FETCH_BYPASS_EN. When defined, a response that
// arrives while the FIFO is empty and decode is not stalled goes straight
// to out_* in the same cycle instead of being written to the FIFO.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   icache_req/addr       word request to the cache, held until granted
//   icache_gnt            request accepted this cycle
//   icache_rvalid/rdata   in-order response, at least one cycle after gnt
//   redirect/redirect_pc  flush and restart fetch at redirect_pc & ~3
//   stall                 decode cannot accept this cycle
//   out_valid/instr/pc    FIFO head (or bypassed response) for decode

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_1000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_gnt,
  input  logic        icache_rvalid,
  input  logic [31:0] icache_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CntW = $clog2(QDEPTH + 1);
  localparam logic [CntW:0]   DepthC  = (CntW + 1)'(QDEPTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(QDEPTH - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       pend_pc_q, pend_pc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]       mem_instr_q [QDEPTH];
  logic [31:0]       mem_pc_q    [QDEPTH];

  logic              fifo_empty;
  logic              head_valid;
  logic              fifo_pop;
  logic              push;
  logic              flush;
  logic              bypass;
  logic [CntW:0]     cnt_ext;

  // Low PC bits are forced to zero on redirect.
  logic              unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty = (cnt_q == '0);
  assign head_valid = !fifo_empty;
  assign cnt_ext    = {1'b0, cnt_q};

`ifdef FETCH_BYPASS_EN
  assign bypass = (state_q == StWait) && icache_rvalid && fifo_empty && !stall && !redirect;
`else
  assign bypass = 1'b0;
`endif

  // Bypassed responses are consumed directly and never occupy the FIFO.
  assign fifo_pop = head_valid && !stall;

  // Outputs
  assign icache_req  = (state_q == StReq);
  assign icache_addr = fetch_pc_q;
  assign out_valid   = head_valid || bypass;

  always_comb begin
    out_instr = '0;
    out_pc    = '0;
    if (bypass) begin
      out_instr = icache_rdata;
      out_pc    = pend_pc_q;
    end else if (head_valid) begin
      out_instr = mem_instr_q[rd_ptr_q];
      out_pc    = mem_pc_q[rd_ptr_q];
    end
  end

  // Fetch FSM
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    push       = 1'b0;
    flush      = 1'b0;

    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      flush      = 1'b1;
      unique case (state_q)
        StIdle: state_d = StReq;
        // A grant in the redirect cycle leaves a stale response to absorb.
        StReq:  state_d = icache_gnt ? StDrop : StReq;
        StWait: state_d = icache_rvalid ? StReq : StDrop;
        StDrop: state_d = icache_rvalid ? StReq : StDrop;
        default: state_d = StIdle;
      endcase
    end else begin
      unique case (state_q)
        StIdle: begin
          // Any response seen here belongs to an abandoned request.
          if (cnt_ext < DepthC) state_d = StReq;
        end
        StReq: begin
          if (icache_gnt) begin
            pend_pc_d  = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = StWait;
          end
        end
        StWait: begin
          if (icache_rvalid) begin
            push = !bypass;
            // A pop in this cycle is deliberately not credited as space.
            state_d = ((cnt_ext + (CntW + 1)'(push)) < DepthC) ? StReq : StIdle;
          end
        end
        StDrop: begin
          if (icache_rvalid) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FIFO bookkeeping
  always_comb begin
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push)     wr_ptr_d = ptr_inc(wr_ptr_q);
      if (fifo_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d = cnt_q + CntW'(push) - CntW'(fifo_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(QDEPTH); i++) begin
        mem_instr_q[i] <= '0;
        mem_pc_q[i]    <= '0;
      end
    end else if (push) begin
      mem_instr_q[wr_ptr_q] <= icache_rdata;
      mem_pc_q[wr_ptr_q]    <= pend_pc_q;
    end
  end

`ifndef SYNTHESIS
  // A response in IDLE is unexpected, except in the first cycle after reset
  // where the reply to a request abandoned by reset may still arrive.
  logic post_rst_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_rst_q <= 1'b1;
    end else begin
      post_rst_q <= 1'b0;
      if (!post_rst_q) begin
        assert (!(icache_rvalid && (state_q == StIdle)));
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_gnt;
  logic        icache_rvalid;
  logic [31:0] icache_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit #(
    .RESET_PC(32'h0000_1000),
    .QDEPTH  (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .icache_req   (icache_req),
    .icache_addr  (icache_addr),
    .icache_gnt   (icache_gnt),
    .icache_rvalid(icache_rvalid),
    .icache_rdata (icache_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .stall        (stall),
    .out_valid    (out_valid),
    .out_instr    (out_instr),
    .out_pc       (out_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  // Expects a pending request at exp_addr, grants it, returns data one cycle
  // later. Ends one cycle after the response.
  task automatic fetch_one(input string tag, input logic [31:0] exp_addr,
                           input logic [31:0] data);
    chk1({tag, "_req"}, icache_req, 1'b1);
    chk32({tag, "_addr"}, icache_addr, exp_addr);
    icache_gnt = 1'b1;
    cyc();
    icache_gnt = 1'b0;
    chk1({tag, "_req_wait"}, icache_req, 1'b0);
    icache_rvalid = 1'b1;
    icache_rdata  = data;
    cyc();
    icache_rvalid = 1'b0;
    icache_rdata  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] instr);
    chk1({tag, "_valid"}, out_valid, v);
    if (v) begin
      chk32({tag, "_pc"}, out_pc, pc);
      chk32({tag, "_instr"}, out_instr, instr);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    icache_gnt    = 1'b0;
    icache_rvalid = 1'b0;
    icache_rdata  = '0;
    redirect      = 1'b0;
    redirect_pc   = '0;
    stall         = 1'b0;

    // Reset state
    cyc();
    cyc();
    chk1("rst_req", icache_req, 1'b0);
    chk32("rst_addr", icache_addr, 32'h0000_1000);
    chk1("rst_valid", out_valid, 1'b0);
    chk32("rst_instr", out_instr, 32'h0);
    chk32("rst_pc", out_pc, 32'h0);
    rst_n = 1'b1;

    // First fetch, no stall
    cyc();
    fetch_one("t1_f0", 32'h0000_1000, 32'hA5A5_0001);
    chk_out("t1_out", 1'b1, 32'h0000_1000, 32'hA5A5_0001);
    chk1("t1_req_next", icache_req, 1'b1);
    chk32("t1_addr_next", icache_addr, 32'h0000_1004);
    cyc();
    chk1("t1_popped", out_valid, 1'b0);

    // Stall fills the FIFO, then drains in order
    do_reset();
    stall = 1'b1;
    cyc();
    fetch_one("t2_f0", 32'h0000_1000, 32'hD000_0000);
    chk_out("t2_one", 1'b1, 32'h0000_1000, 32'hD000_0000);
    fetch_one("t2_f1", 32'h0000_1004, 32'hD000_0001);
    for (int i = 0; i < 3; i++) begin
      chk1("t2_full_noreq", icache_req, 1'b0);
      chk_out("t2_hold", 1'b1, 32'h0000_1000, 32'hD000_0000);
      cyc();
    end
    stall = 1'b0;
    cyc();
    chk_out("t2_pop1", 1'b1, 32'h0000_1004, 32'hD000_0001);
    chk1("t2_pop1_noreq", icache_req, 1'b0);
    cyc();
    chk1("t2_empty", out_valid, 1'b0);
    chk1("t2_resume_req", icache_req, 1'b1);
    chk32("t2_resume_addr", icache_addr, 32'h0000_1008);

    // Redirect in WAIT with rvalid, FIFO non-empty
    do_reset();
    stall = 1'b1;
    cyc();
    fetch_one("t3_f0", 32'h0000_1000, 32'hA000_0001);
    icache_gnt = 1'b1;
    cyc();
    icache_gnt    = 1'b0;
    redirect      = 1'b1;
    redirect_pc   = 32'h0000_2003;
    icache_rvalid = 1'b1;
    icache_rdata  = 32'hBAD0_0001;
    cyc();
    redirect      = 1'b0;
    icache_rvalid = 1'b0;
    chk1("t3_flush", out_valid, 1'b0);
    chk1("t3_req", icache_req, 1'b1);
    chk32("t3_addr", icache_addr, 32'h0000_2000);
    stall = 1'b0;
    fetch_one("t3_f1", 32'h0000_2000, 32'hC000_0001);
    chk_out("t3_out", 1'b1, 32'h0000_2000, 32'hC000_0001);
    // Redirect in WAIT without rvalid goes through DROP
    icache_gnt = 1'b1;
    cyc();
    icache_gnt  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3000;
    cyc();
    redirect = 1'b0;
    chk1("t3_drop_req", icache_req, 1'b0);
    chk1("t3_drop_valid", out_valid, 1'b0);
    chk32("t3_drop_addr", icache_addr, 32'h0000_3000);
    icache_rvalid = 1'b1;
    icache_rdata  = 32'hBAD0_0002;
    cyc();
    icache_rvalid = 1'b0;
    chk1("t3_dropped", out_valid, 1'b0);
    chk1("t3_idle_req", icache_req, 1'b0);
    cyc();
    chk1("t3_restart_req", icache_req, 1'b1);
    chk32("t3_restart_addr", icache_addr, 32'h0000_3000);

    // Redirect in the same cycle as gnt
    do_reset();
    cyc();
    fetch_one("t4_f0", 32'h0000_1000, 32'hB000_0001);
    icache_gnt  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_4000;
    cyc();
    icache_gnt = 1'b0;
    redirect   = 1'b0;
    chk1("t4_drop_req", icache_req, 1'b0);
    chk1("t4_flush", out_valid, 1'b0);
    chk32("t4_addr", icache_addr, 32'h0000_4000);
    icache_rvalid = 1'b1;
    icache_rdata  = 32'hBAD0_0003;
    cyc();
    icache_rvalid = 1'b0;
    chk1("t4_dropped", out_valid, 1'b0);
    cyc();
    fetch_one("t4_f1", 32'h0000_4000, 32'hB000_0002);
    chk_out("t4_out", 1'b1, 32'h0000_4000, 32'hB000_0002);

    // PC wrap at the top of the address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect = 1'b0;
    chk1("t5_flush", out_valid, 1'b0);
    fetch_one("t5_f0", 32'hFFFF_FFFC, 32'hE000_0001);
    chk_out("t5_out0", 1'b1, 32'hFFFF_FFFC, 32'hE000_0001);
    fetch_one("t5_f1", 32'h0000_0000, 32'hE000_0002);
    chk_out("t5_out1", 1'b1, 32'h0000_0000, 32'hE000_0002);

    // Reset while WAIT, responses during and just after reset
    icache_gnt = 1'b1;
    cyc();
    icache_gnt    = 1'b0;
    rst_n         = 1'b0;
    icache_rvalid = 1'b1;
    icache_rdata  = 32'hBAD0_0004;
    #1;
    chk1("t6_rst_req", icache_req, 1'b0);
    chk1("t6_rst_valid", out_valid, 1'b0);
    chk32("t6_rst_addr", icache_addr, 32'h0000_1000);
    cyc();
    rst_n = 1'b1;
    cyc();
    icache_rvalid = 1'b0;
    chk1("t6_ignored", out_valid, 1'b0);
    fetch_one("t6_f0", 32'h0000_1000, 32'hF000_0001);
    chk_out("t6_out", 1'b1, 32'h0000_1000, 32'hF000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
